// File: rtl/motion_detect_pkg.sv
// Shared constants and FSM state type for the motion-mask pipeline.
package motion_detect_pkg;

  localparam int unsigned DEFAULT_WIDTH     = 768;
  localparam int unsigned DEFAULT_HEIGHT    = 576;
  localparam logic [7:0]  DEFAULT_THRESHOLD = 8'd50;

  localparam logic [7:0] MASK_ON  = 8'hFF;
  localparam logic [7:0] MASK_OFF = 8'h00;

  typedef enum logic {
    S_READ  = 1'b0,
    S_WRITE = 1'b1
  } state_e;

endpackage

// File: rtl/abs_diff_thresh.sv
// Absolute grayscale difference compared against a threshold; purely combinational.
module abs_diff_thresh
  import motion_detect_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] threshold,
  output logic [7:0] mask
);

  logic [8:0] diff_wide;
  logic [7:0] diff;

  always_comb begin
    diff_wide = {1'b0, a} - {1'b0, b};
    // Bit 8 is the borrow: when set, the low byte holds 256 - |a - b|.
    diff      = diff_wide[8] ? (8'd0 - diff_wide[7:0]) : diff_wide[7:0];
    mask      = (diff > threshold) ? MASK_ON : MASK_OFF;
  end

endmodule

// File: rtl/motion_mask.sv
// Pops paired background/frame pixels, writes a binary motion mask, flags end of frame.
module motion_mask
  import motion_detect_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned HEIGHT    = DEFAULT_HEIGHT,
  parameter logic [7:0]  THRESHOLD = DEFAULT_THRESHOLD
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       bg_empty,
  input  logic [7:0] bg_dout,
  output logic       bg_re,
  input  logic       frame_empty,
  input  logic [7:0] frame_dout,
  output logic       frame_re,
  input  logic       mask_full,
  output logic       mask_we,
  output logic [7:0] mask_din,
  output logic       frame_done
);

  localparam int unsigned NumPix  = WIDTH * HEIGHT;
  localparam int unsigned CntW    = (NumPix > 1) ? $clog2(NumPix) : 1;
  localparam logic [CntW-1:0] LastPix = CntW'(NumPix - 1);

  state_e          state_q, state_d;
  logic [7:0]      mask_q, mask_d, mask_new;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pop;

  abs_diff_thresh u_abs_diff_thresh (
    .a        (frame_dout),
    .b        (bg_dout),
    .threshold(THRESHOLD),
    .mask     (mask_new)
  );

  always_comb begin
    // A single pop strobe keeps the two input FIFOs in lockstep.
    pop        = (state_q == S_READ) && !bg_empty && !frame_empty;
    bg_re      = pop;
    frame_re   = pop;
    mask_we    = (state_q == S_WRITE) && !mask_full;
    mask_din   = mask_q;
    frame_done = mask_we && (cnt_q == LastPix);

    state_d = state_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    if (pop) begin
      state_d = S_WRITE;
      mask_d  = mask_new;
    end
    if (mask_we) begin
      state_d = S_READ;
      cnt_d   = (cnt_q == LastPix) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_READ;
      mask_q  <= MASK_OFF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_motion_mask.sv
// Self-checking bench for motion_mask on a 4x2 frame with a pixel-level reference model.
module tb_motion_mask;

  localparam int unsigned W    = 4;
  localparam int unsigned H    = 2;
  localparam int          NPIX = W * H;
  localparam logic [7:0]  THR  = 8'd50;

  logic       clock, reset;
  logic       bg_empty, frame_empty, mask_full;
  logic [7:0] bg_dout, frame_dout, mask_din;
  logic       bg_re, frame_re, mask_we, frame_done;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;

  motion_mask #(
    .WIDTH    (W),
    .HEIGHT   (H),
    .THRESHOLD(THR)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .bg_empty   (bg_empty),
    .bg_dout    (bg_dout),
    .bg_re      (bg_re),
    .frame_empty(frame_empty),
    .frame_dout (frame_dout),
    .frame_re   (frame_re),
    .mask_full  (mask_full),
    .mask_we    (mask_we),
    .mask_din   (mask_din),
    .frame_done (frame_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] ref_mask(input logic [7:0] bg, input logic [7:0] fr);
    int d;
    d = int'(fr) - int'(bg);
    if (d < 0) d = -d;
    return (d > int'(THR)) ? 8'hFF : 8'h00;
  endfunction

  // Writes since the last reset; the final pixel of each frame is index NPIX-1.
  function automatic logic ref_done();
    return (wr_cnt % NPIX) == (NPIX - 1);
  endfunction

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b0; bg_empty = 1'b1; frame_empty = 1'b1; mask_full = 1'b0;
    bg_dout = 8'h00; frame_dout = 8'h00;
    repeat (2) @(negedge clock);
    #1;
    checks++;
    if ({bg_re, frame_re, mask_we, frame_done} !== 4'b0000 || mask_din !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got re=%b/%b we=%b done=%b din=%h, want all 0",
               bg_re, frame_re, mask_we, frame_done, mask_din);
    end
    @(negedge clock);
    reset = 1'b1;
    wr_cnt = 0;
    #1;
    checks++;
    if ({bg_re, frame_re, mask_we, frame_done} !== 4'b0000 || mask_din !== 8'h00) begin
      errors++;
      $display("FAIL post_reset_outputs: got re=%b/%b we=%b done=%b din=%h, want all 0",
               bg_re, frame_re, mask_we, frame_done, mask_din);
    end
  endtask

  task automatic test_threshold();
    logic [7:0] tb_bg [5] = '{8'd100, 8'd100, 8'd200, 8'd0,   8'd77};
    logic [7:0] tb_fr [5] = '{8'd151, 8'd150, 8'd10,  8'd255, 8'd77};
    logic [7:0] tb_ex [5] = '{8'hFF,  8'h00,  8'hFF,  8'hFF,  8'h00};
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      bg_dout = tb_bg[i]; frame_dout = tb_fr[i];
      bg_empty = 1'b0; frame_empty = 1'b0; mask_full = 1'b0;
      #1;
      checks++;
      if ({bg_re, frame_re} !== 2'b11) begin
        errors++;
        $display("FAIL thr_pop[%0d]: got re=%b/%b, want 1/1", i, bg_re, frame_re);
      end
      @(negedge clock);
      bg_empty = 1'b1; frame_empty = 1'b1;
      #1;
      checks++;
      if (mask_we !== 1'b1 || mask_din !== tb_ex[i] || frame_done !== ref_done()) begin
        errors++;
        $display("FAIL thr_write[%0d]: got we=%b din=%h done=%b, want we=1 din=%h done=%b",
                 i, mask_we, mask_din, frame_done, tb_ex[i], ref_done());
      end
      wr_cnt++;
    end
  endtask

  task automatic test_stall();
    @(negedge clock);
    bg_dout = 8'd100; frame_dout = 8'd200;
    bg_empty = 1'b0; frame_empty = 1'b0; mask_full = 1'b0;
    #1;
    checks++;
    if ({bg_re, frame_re} !== 2'b11) begin
      errors++;
      $display("FAIL stall_pop: got re=%b/%b, want 1/1", bg_re, frame_re);
    end
    @(negedge clock);
    mask_full = 1'b1;
    for (int s = 0; s < 10; s++) begin
      #1;
      checks++;
      if ({bg_re, frame_re, mask_we} !== 3'b000) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got re=%b/%b we=%b, want 0/0 0",
                 s, bg_re, frame_re, mask_we);
      end
      @(negedge clock);
    end
    mask_full = 1'b0;
    #1;
    checks++;
    if (mask_we !== 1'b1 || mask_din !== 8'hFF || frame_done !== ref_done()) begin
      errors++;
      $display("FAIL stall_release: got we=%b din=%h done=%b, want we=1 din=ff done=%b",
               mask_we, mask_din, frame_done, ref_done());
    end
    wr_cnt++;
  endtask

  task automatic test_one_sided();
    logic [7:0] b, f;
    for (int side = 0; side < 2; side++) begin
      b = 8'($urandom_range(0, 255));
      f = 8'($urandom_range(0, 255));
      @(negedge clock);
      bg_dout = b; frame_dout = f; mask_full = 1'b0;
      bg_empty = (side == 1); frame_empty = (side == 0);
      for (int c = 0; c < 5; c++) begin
        #1;
        checks++;
        if ({bg_re, frame_re, mask_we} !== 3'b000) begin
          errors++;
          $display("FAIL one_sided[%0d.%0d]: got re=%b/%b we=%b, want 0/0 0",
                   side, c, bg_re, frame_re, mask_we);
        end
        @(negedge clock);
      end
      bg_empty = 1'b0; frame_empty = 1'b0;
      #1;
      checks++;
      if ({bg_re, frame_re} !== 2'b11) begin
        errors++;
        $display("FAIL one_sided_pop[%0d]: got re=%b/%b, want 1/1", side, bg_re, frame_re);
      end
      @(negedge clock);
      bg_empty = 1'b1; frame_empty = 1'b1;
      #1;
      checks++;
      if (mask_we !== 1'b1 || mask_din !== ref_mask(b, f) || frame_done !== ref_done()) begin
        errors++;
        $display("FAIL one_sided_write[%0d]: got we=%b din=%h done=%b, want we=1 din=%h done=%b",
                 side, mask_we, mask_din, frame_done, ref_mask(b, f), ref_done());
      end
      wr_cnt++;
    end
  endtask

  // Back-to-back stream: the next pixel is already waiting while each write is pending.
  task automatic test_back_to_back(input int n, input int max_stall);
    logic [7:0] bq[$], fq[$];
    logic [7:0] exp;
    int stall;
    for (int i = 0; i <= n; i++) begin
      bq.push_back(8'($urandom_range(0, 255)));
      fq.push_back(8'($urandom_range(0, 255)));
    end
    for (int i = 0; i < n; i++) begin
      exp = ref_mask(bq[0], fq[0]);
      @(negedge clock);
      bg_dout = bq[0]; frame_dout = fq[0];
      bg_empty = 1'b0; frame_empty = 1'b0; mask_full = 1'b0;
      #1;
      checks++;
      if ({bg_re, frame_re, mask_we} !== 3'b110) begin
        errors++;
        $display("FAIL b2b_pop[%0d]: got re=%b/%b we=%b, want 1/1 0",
                 i, bg_re, frame_re, mask_we);
      end
      void'(bq.pop_front());
      void'(fq.pop_front());
      stall = $urandom_range(0, max_stall);
      @(negedge clock);
      bg_dout = bq[0]; frame_dout = fq[0];
      mask_full = (stall > 0);
      for (int s = 0; s < stall; s++) begin
        #1;
        checks++;
        if ({bg_re, frame_re, mask_we} !== 3'b000) begin
          errors++;
          $display("FAIL b2b_stall[%0d.%0d]: got re=%b/%b we=%b, want 0/0 0",
                   i, s, bg_re, frame_re, mask_we);
        end
        @(negedge clock);
        if (s == stall - 1) mask_full = 1'b0;
      end
      #1;
      checks++;
      if ({bg_re, frame_re, mask_we} !== 3'b001 || mask_din !== exp ||
          frame_done !== ref_done()) begin
        errors++;
        $display("FAIL b2b_write[%0d]: got re=%b/%b we=%b din=%h done=%b, want 0/0 1 din=%h done=%b",
                 i, bg_re, frame_re, mask_we, mask_din, frame_done, exp, ref_done());
      end
      wr_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    bg_dout = 8'd0; frame_dout = 8'd255;
    bg_empty = 1'b0; frame_empty = 1'b0; mask_full = 1'b0;
    #1;
    checks++;
    if ({bg_re, frame_re} !== 2'b11) begin
      errors++;
      $display("FAIL mid_pop: got re=%b/%b, want 1/1", bg_re, frame_re);
    end
    @(negedge clock);
    bg_empty = 1'b1; frame_empty = 1'b1; mask_full = 1'b1;
    #1;
    checks++;
    if (mask_we !== 1'b0 || mask_din !== 8'hFF) begin
      errors++;
      $display("FAIL mid_held: got we=%b din=%h, want we=0 din=ff", mask_we, mask_din);
    end
    @(negedge clock);
    reset = 1'b0;
    #1;
    checks++;
    if (mask_we !== 1'b0) begin
      errors++;
      $display("FAIL mid_no_write: got we=%b, want 0", mask_we);
    end
    @(negedge clock);
    #1;
    checks++;
    if ({bg_re, frame_re, mask_we, frame_done} !== 4'b0000 || mask_din !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset_outputs: got re=%b/%b we=%b done=%b din=%h, want all 0",
               bg_re, frame_re, mask_we, frame_done, mask_din);
    end
    reset = 1'b1;
    mask_full = 1'b0;
    wr_cnt = 0;
    #1;
    checks++;
    if (mask_we !== 1'b0) begin
      errors++;
      $display("FAIL mid_discard: got we=%b, want 0", mask_we);
    end
  endtask

  initial begin
    reset = 1'b0; bg_empty = 1'b1; frame_empty = 1'b1; mask_full = 1'b0;
    bg_dout = 8'h00; frame_dout = 8'h00;
    test_reset();
    test_threshold();
    test_stall();
    test_one_sided();
    test_back_to_back(4, 0);
    test_reset();
    test_back_to_back(16, 3);
    test_back_to_back(2, 0);
    test_reset_mid();
    test_back_to_back(8, 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
